dwt53_row_fwd: RTL and testbench

DWT53_ROW_FWD -- requirements
Module: dwt53_row_fwd

---
 rtl/dwt53_row_fwd_if.sv | 14 +
 rtl/dwt53_row_fwd.sv | 185 ++++++++++++++++++
 tb/tb_dwt53_row_fwd.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dwt53_row_fwd_if.sv
// Valid/ready sample stream with frame-start and line-end markers.
// The block consumes on a slave port and produces on a master port.
interface dwt53_row_fwd_if #(
  parameter int Width = 8
);
  logic [Width-1:0] data;
  logic             valid;
  logic             ready;
  logic             sof;
  logic             eol;

  modport master (output data, valid, sof, eol, input ready);
  modport slave  (input data, valid, sof, eol, output ready);
endinterface

// File: rtl/dwt53_row_fwd.sv
// Forward 5/3 integer lifting along each line, streaming with no line buffer.
// Emits interleaved s/d coefficients two samples behind the input; the line tail drains in FLUSH.
module dwt53_row_fwd #(
  parameter int DataWidth = 8,
  parameter int OutWidth  = DataWidth + 2
) (
  input  logic clk,
  input  logic rst,
  dwt53_row_fwd_if.slave  in_if,
  dwt53_row_fwd_if.master out_if
);

  // One guard bit above the output width holds d[k-1]+d[k]+2 without overflow.
  localparam int W = OutWidth + 1;
  localparam logic signed [W-1:0] Two = W'(2);

  typedef enum logic [1:0] {FIRST, ODD, EVEN, FLUSH} state_t;

  state_t state, state_nx;

  logic signed [W-1:0] x_even, x_odd, d_prev, d_pend, t0, t1;
  logic [1:0]          tail_cnt;
  logic                first_pair, sof_line, ready_en;

  logic [OutWidth-1:0] out_data_r;
  logic                out_valid_r, out_sof_r, out_eol_r;

  logic                in_ready_w, out_free, accept;
  logic signed [W-1:0] x_in, d_even, s_even, s_tail_even, d_odd, s_odd;

  logic                emit, emit_sof, emit_eol, tail_ld;
  logic signed [W-1:0] emit_val, tail_a, tail_b;
  logic [1:0]          tail_n;

  assign out_free   = !out_valid_r || out_if.ready;
  assign in_ready_w = ready_en && (state != FLUSH) && out_free;
  assign accept     = in_if.valid && in_ready_w;

  assign in_if.ready  = in_ready_w;
  assign out_if.data  = out_data_r;
  assign out_if.valid = out_valid_r;
  assign out_if.sof   = out_sof_r;
  assign out_if.eol   = out_eol_r;

  assign x_in = {{(W - DataWidth){in_if.data[DataWidth-1]}}, in_if.data};

  // Even sample arriving: x_in is x[2k+2], completing d[k] and s[k].
  assign d_even      = x_odd - ((x_even + x_in) >>> 1);
  assign s_even      = x_even + (((first_pair ? d_even : d_prev) + d_even + Two) >>> 2);
  assign s_tail_even = x_in + ((d_even + d_even + Two) >>> 2);
  // Odd sample with eol: mirrored x[N] equals x[N-2], so d reduces to a difference.
  assign d_odd       = x_in - x_even;
  assign s_odd       = x_even + (((first_pair ? d_odd : d_prev) + d_odd + Two) >>> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FIRST;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    state_nx = state;
    emit     = 1'b0;
    emit_val = '0;
    emit_sof = 1'b0;
    emit_eol = 1'b0;
    tail_ld  = 1'b0;
    tail_a   = '0;
    tail_b   = '0;
    tail_n   = 2'd0;
    case (state)
      FIRST: if (accept) begin
        if (in_if.eol) begin
          emit     = 1'b1;
          emit_val = x_in;
          emit_sof = in_if.sof;
          emit_eol = 1'b1;
          tail_ld  = 1'b1;
          state_nx = FLUSH;
        end else begin
          state_nx = ODD;
        end
      end
      ODD: if (accept) begin
        emit = !first_pair || in_if.eol;
        if (in_if.eol) begin
          tail_ld  = 1'b1;
          state_nx = FLUSH;
          if (first_pair) begin
            emit_val = s_odd;
            emit_sof = sof_line;
            tail_a   = d_odd;
            tail_n   = 2'd1;
          end else begin
            emit_val = d_pend;
            tail_a   = s_odd;
            tail_b   = d_odd;
            tail_n   = 2'd2;
          end
        end else begin
          emit_val = d_pend;
          state_nx = EVEN;
        end
      end
      EVEN: if (accept) begin
        emit     = 1'b1;
        emit_val = s_even;
        emit_sof = first_pair && sof_line;
        if (in_if.eol) begin
          tail_ld  = 1'b1;
          tail_a   = d_even;
          tail_b   = s_tail_even;
          tail_n   = 2'd2;
          state_nx = FLUSH;
        end else begin
          state_nx = ODD;
        end
      end
      FLUSH: if (out_free) begin
        if (tail_cnt == 2'd0) begin
          state_nx = FIRST;
        end else begin
          emit     = 1'b1;
          emit_val = t0;
          emit_eol = (tail_cnt == 2'd1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      ready_en    <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sof_r   <= 1'b0;
      out_eol_r   <= 1'b0;
      x_even      <= '0;
      x_odd       <= '0;
      d_prev      <= '0;
      d_pend      <= '0;
      t0          <= '0;
      t1          <= '0;
      tail_cnt    <= 2'd0;
      first_pair  <= 1'b0;
      sof_line    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (out_valid_r && out_if.ready) out_valid_r <= 1'b0;
      if (emit) begin
        out_valid_r <= 1'b1;
        out_data_r  <= OutWidth'(emit_val);
        out_sof_r   <= emit_sof;
        out_eol_r   <= emit_eol;
      end
      if (tail_ld) begin
        t0       <= tail_a;
        t1       <= tail_b;
        tail_cnt <= tail_n;
      end else if (state == FLUSH && emit) begin
        t0       <= t1;
        tail_cnt <= tail_cnt - 2'd1;
      end
      if (accept) begin
        case (state)
          FIRST: begin
            x_even     <= x_in;
            sof_line   <= in_if.sof;
            first_pair <= 1'b1;
          end
          ODD:  x_odd <= x_in;
          EVEN: begin
            x_even     <= x_in;
            d_prev     <= d_even;
            d_pend     <= d_even;
            first_pair <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dwt53_row_fwd.sv
// Self-checking bench for dwt53_row_fwd: directed vector table, mid-line reset,
// and randomized handshakes against a whole-line lifting reference model.
module tb_dwt53_row_fwd;

  localparam int DW = 8;
  localparam int OW = 10;

  typedef struct {
    int data;
    bit sof;
    bit eol;
  } out_t;

  typedef struct packed {
    logic [3:0]         n;
    logic               sof;
    logic [7:0][DW-1:0] x;
    logic [7:0][OW-1:0] y;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dwt53_row_fwd_if #(.Width(DW)) in_if ();
  dwt53_row_fwd_if #(.Width(OW)) out_if ();

  dwt53_row_fwd #(.DataWidth(DW), .OutWidth(OW)) dut (
    .clk   (clk),
    .rst   (rst),
    .in_if (in_if),
    .out_if(out_if)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   hold_ready = 1'b0;
  bit   rand_ready = 1'b0;
  out_t got[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Downstream ready, changed just after each rising edge.
  initial begin
    out_if.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_if.ready = hold_ready ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Output monitor: records transfers and checks data stays put while stalled.
  logic [OW-1:0] prev_data;
  bit            prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!rst && prev_stall) begin
      check("hold_valid", int'(out_if.valid), 1);
      check("hold_data", int'(out_if.data), int'(prev_data));
    end
    prev_stall = !rst && out_if.valid && !out_if.ready;
    prev_data  = out_if.data;
    if (!rst && out_if.valid && out_if.ready)
      got.push_back('{int'($signed(out_if.data)), out_if.sof, out_if.eol});
  end

  // Reference: whole-line forward 5/3 lifting with symmetric extension.
  function automatic void dwt_ref(input int x[$], output int y[$]);
    int n = x.size();
    int d[$];
    int nd, ns, xr, dl, dr;
    y = {};
    if (n == 1) begin
      y.push_back(x[0]);
      return;
    end
    nd = n / 2;
    ns = (n + 1) / 2;
    for (int k = 0; k < nd; k++) begin
      xr = (2 * k + 2 < n) ? x[2 * k + 2] : x[n - 2];
      d.push_back(x[2 * k + 1] - ((x[2 * k] + xr) >>> 1));
    end
    for (int k = 0; k < ns; k++) begin
      dl = (k == 0) ? d[0] : d[k - 1];
      dr = (k < nd) ? d[k] : d[nd - 1];
      y.push_back(x[2 * k] + ((dl + dr + 2) >>> 2));
      if (k < nd) y.push_back(d[k]);
    end
  endfunction

  function automatic vec_t mk(input int n, input bit sof, input int xs[8], input int ys[8]);
    vec_t v;
    v.n   = n[3:0];
    v.sof = sof;
    for (int i = 0; i < 8; i++) begin
      v.x[i] = xs[i][DW-1:0];
      v.y[i] = ys[i][OW-1:0];
    end
    return v;
  endfunction

  task automatic send_sample(input int x, input bit sof, input bit eol, input bit gaps,
                             output int waits);
    waits = 0;
    @(posedge clk);
    #1;
    if (gaps) begin
      in_if.valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    in_if.valid = 1'b1;
    in_if.data  = x[DW-1:0];
    in_if.sof   = sof;
    in_if.eol   = eol;
    @(negedge clk);
    while (!in_if.ready && waits < 1000) begin
      waits++;
      @(negedge clk);
    end
    if (!in_if.ready) check("accept_timeout", 0, 1);
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    in_if.sof   = 1'b0;
    in_if.eol   = 1'b0;
  endtask

  task automatic send_line(input int xs[$], input bit sof, input bit gaps, input bit chk_tp);
    int w;
    bit s;
    for (int i = 0; i < xs.size(); i++) begin
      s = (i == 0) ? sof : (gaps ? bit'($urandom_range(0, 1)) : 1'b0);
      send_sample(xs[i], s, i == xs.size() - 1, gaps, w);
      if (chk_tp) begin
        if (i > 0) check("stall_in_line", w, 0);
        else       check("boundary_bubbles_le3", int'(w <= 3), 1);
      end
    end
  endtask

  task automatic compare_outputs(input out_t exp[$], input string tag);
    int   cyc = 0;
    out_t o;
    while (got.size() < exp.size() && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (got.size() == 0) break;
      o = got.pop_front();
      check($sformatf("%s[%0d].data", tag, i), o.data, exp[i].data);
      check($sformatf("%s[%0d].sof", tag, i), int'(o.sof), int'(exp[i].sof));
      check($sformatf("%s[%0d].eol", tag, i), int'(o.eol), int'(exp[i].eol));
    end
    repeat (20) @(negedge clk);
    check({tag, "_extra"}, got.size(), 0);
    got = {};
  endtask

  task automatic expect_line(input int y[$], input bit sof, inout out_t exp[$]);
    for (int i = 0; i < y.size(); i++)
      exp.push_back('{y[i], sof && (i == 0), i == y.size() - 1});
  endtask

  vec_t tbl[5];

  initial begin
    out_t exp[$];
    int   xs[$];
    int   ys[$];
    int   n;

    tbl[0] = mk(4, 1'b1, '{10, 20, 30, 40, 0, 0, 0, 0}, '{10, 0, 33, 10, 0, 0, 0, 0});
    tbl[1] = mk(8, 1'b0, '{5, 5, 5, 5, 5, 5, 5, 5},     '{5, 0, 5, 0, 5, 0, 5, 0});
    tbl[2] = mk(3, 1'b0, '{4, 8, 2, 0, 0, 0, 0, 0},     '{7, 5, 5, 0, 0, 0, 0, 0});
    tbl[3] = mk(1, 1'b1, '{-3, 0, 0, 0, 0, 0, 0, 0},    '{-3, 0, 0, 0, 0, 0, 0, 0});
    tbl[4] = mk(4, 1'b0, '{0, 1, 1, 0, 0, 0, 0, 0},     '{1, 1, 1, -1, 0, 0, 0, 0});

    in_if.valid = 1'b0;
    in_if.data  = '0;
    in_if.sof   = 1'b0;
    in_if.eol   = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_if.valid), 0);
    check("rst_out_sof", int'(out_if.sof), 0);
    check("rst_out_eol", int'(out_if.eol), 0);
    check("rst_out_data", int'(out_if.data), 0);
    check("rst_in_ready", int'(in_if.ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_rst", int'(in_if.ready), 1);

    // Directed table, lines back to back at full rate
    exp = {};
    for (int t = 0; t < 5; t++) begin
      xs = {};
      ys = {};
      for (int i = 0; i < int'(tbl[t].n); i++) begin
        xs.push_back(int'($signed(tbl[t].x[i])));
        ys.push_back(int'($signed(tbl[t].y[i])));
      end
      send_line(xs, tbl[t].sof, 1'b0, 1'b1);
      expect_line(ys, tbl[t].sof, exp);
    end
    go_idle();
    compare_outputs(exp, "table");

    // Reset after three samples of a line discards it
    hold_ready = 1'b1;
    xs = {1, 2, 3, 4};
    for (int i = 0; i < 3; i++) send_sample(xs[i], i == 0, 1'b0, 1'b0, n);
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hold_ready = 1'b0;
    check("rst_midline_no_out", got.size(), 0);
    exp = {};
    send_line('{10, 20, 30, 40}, 1'b1, 1'b0, 1'b0);
    go_idle();
    expect_line('{10, 0, 33, 10}, 1'b1, exp);
    compare_outputs(exp, "after_rst");

    // Randomized: 8 lines of 8, then a few odd lengths, random valid/ready
    rand_ready = 1'b1;
    exp = {};
    for (int l = 0; l < 12; l++) begin
      n  = (l < 8) ? 8 : $urandom_range(1, 7);
      xs = {};
      for (int i = 0; i < n; i++) xs.push_back(int'($urandom_range(0, 255)) - 128);
      dwt_ref(xs, ys);
      send_line(xs, (l % 4) == 0, 1'b1, 1'b0);
      expect_line(ys, (l % 4) == 0, exp);
    end
    go_idle();
    compare_outputs(exp, "rand");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
